prog_loader: RTL



---
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream ingress and instruction-memory write port of the program loader.
// Latency: none; plain wires between the loader and its environment.
// Backpressure: in_ready gates the byte stream; memory writes are never stalled.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;

  // Loader side: sinks the byte stream, sources memory writes.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wd
  );

  // Environment side: sources the byte stream, sinks memory writes.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/prog_loader.sv
// Streams little-endian bytes into 32-bit instruction words, writes them to memory, then releases the core.
// Latency: one WRITE cycle after the 4th byte of each word; RUN the cycle after the last WRITE.
// Backpressure: in_ready is high only in LOAD (state-derived); a stalled stream times out into ERR.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  len_words,
  prog_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         busy,
  output logic         err
);

  // The idle counter only has to reach TIMEOUT-1: the next idle edge goes to ERR.
  localparam int unsigned IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [15:0]   len_q, len_d;
  logic [31:0]   wbuf_q, wbuf_d;

  logic          len_bad;
  logic [15:0]   word_inc;

  assign len_bad  = (len_words == 16'd0) || (32'(len_words) > MAX_WORDS);
  assign word_inc = word_idx_q + 16'd1;

  // Next-state, datapath updates and state-derived outputs.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    idle_d     = idle_q;
    len_d      = len_q;
    wbuf_d     = wbuf_q;

    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
    bus.mem_wd   = wbuf_q;
    cpu_rst      = 1'b1;
    busy         = 1'b0;
    err          = 1'b0;

    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        cpu_rst = (state_q != S_RUN);
        err     = (state_q == S_ERR);
        if (start) begin
          if (len_bad) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_LOAD;
            word_idx_d = 16'd0;
            byte_idx_d = 2'd0;
            idle_d     = '0;
            len_d      = len_words;
          end
        end
      end

      S_LOAD: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (bus.in_valid) begin
          // A transfer always beats a timeout landing in the same cycle.
          wbuf_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          idle_d     = '0;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d = S_ERR;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end

      S_WRITE: begin
        bus.mem_we = 1'b1;
        busy       = 1'b1;
        word_idx_d = word_inc;
        state_d    = (word_inc == len_q) ? S_RUN : S_LOAD;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      word_idx_q <= 16'd0;
      byte_idx_q <= 2'd0;
      idle_q     <= '0;
      len_q      <= 16'd0;
      wbuf_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      idle_q     <= idle_d;
      len_q      <= len_d;
      wbuf_q     <= wbuf_d;
    end
  end

endmodule
